// File: rtl/sync_dualport_ram_be.sv
// sync_dualport_ram_be: single-clock simple dual-port RAM with byte enables, selectable read latency and sequenced clear
module sync_dualport_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE = 0,
  localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err_addr
);
  typedef enum logic {INIT, IDLE} state_t;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word, rd1_q;
  logic rd1_v_q, wr_in, rd_in, wr_fire, rd_fire, err_d;
  assign busy = state_q == INIT;
  assign wr_in = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in = {1'b0, rd_addr} < DEPTH_W;
  assign wr_fire = !busy && wr_en && wr_in;
  assign rd_fire = !busy && rd_en;
  assign err_d = !busy && ((rd_en && !rd_in) || (wr_en && !wr_in && |wr_be));
  // Clear sequencer: walk ptr over every word, then idle until a clear request
  always_comb begin
    state_d = busy ? (ptr_q == LAST ? IDLE : INIT) : (clear ? INIT : IDLE);
    ptr_d = (busy && ptr_q != LAST) ? ptr_q + 1'b1 : '0;
  end
  // Sequencer state; reset restarts the clear from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  // Array: clearing overrides requests, otherwise per-lane write
  always_ff @(posedge clk) begin
    if (busy) mem[ptr_q] <= '0;
    else
      for (int k = 0; k < NB; k++)
        if (wr_fire && wr_be[k]) mem[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
  end
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] =
      (RDW_MODE == 0 && wr_fire && wr_addr == rd_addr && wr_be[k]) ? wr_data[k*BYTE_WIDTH +: BYTE_WIDTH]
                                                                    : mem[rd_addr][k*BYTE_WIDTH +: BYTE_WIDTH];
  end
  // First read stage plus error pulse; data holds when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd1_v_q <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      rd1_v_q <= rd_fire;
      err_addr <= err_d;
      if (rd_fire) rd1_q <= rd_in ? rd_word : '0;
    end
  end
  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_q;
    logic rd2_v_q;
    // Optional second output register stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd2_q <= '0;
        rd2_v_q <= 1'b0;
      end else begin
        rd2_q <= rd1_q;
        rd2_v_q <= rd1_v_q;
      end
    end
    assign rd_data = rd2_q;
    assign rd_valid = rd2_v_q;
  end else begin : g_lat1
    assign rd_data = rd1_q;
    assign rd_valid = rd1_v_q;
  end
endmodule

// File: tb/tb_sync_dualport_ram_be.sv
// tb_sync_dualport_ram_be: two configurations driven in parallel against an array-level reference model
module tb_sync_dualport_ram_be;
  logic clk = 0, rst_n = 0, clear = 0, wr_en = 0, rd_en = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [15:0] wr_data = 0;
  logic [1:0] wr_be = 0;
  logic [15:0] od [2];
  logic ov [2], ob [2], oe [2];
  int checks = 0, failures = 0;
  int dp [2] = '{8, 6};
  int md [2] = '{0, 1};
  logic [15:0] m [2][8];
  int cnt [2];
  logic [15:0] s1d [2], s2d [2];
  logic s1v [2], s2v [2], e [2];
  always #5 clk = ~clk;
  sync_dualport_ram_be u_a (.clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(od[0]), .rd_valid(ov[0]),
    .busy(ob[0]), .err_addr(oe[0]));
  sync_dualport_ram_be #(.DEPTH(6), .RDW_MODE(1), .RD_LATENCY(2)) u_b (.clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(od[1]), .rd_valid(ov[1]), .busy(ob[1]), .err_addr(oe[1]));
  function automatic logic [15:0] ed(int i);
    return i == 0 ? s1d[0] : s2d[1];
  endfunction
  function automatic logic ev(int i);
    return i == 0 ? s1v[0] : s2v[1];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = dp[i];
      s1d[i] = 0; s2d[i] = 0; s1v[i] = 0; s2v[i] = 0; e[i] = 0;
      for (int j = 0; j < 8; j++) m[i][j] = 0;
    end
  endtask
  task automatic idle();
    clear = 0; wr_en = 0; rd_en = 0; wr_be = 0;
  endtask
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] nd;
      logic nv, ne;
      nd = s1d[i]; nv = 0; ne = 0;
      if (cnt[i] > 0) cnt[i]--;
      else begin
        if (rd_en) begin
          nv = 1;
          nd = 0;
          if (rd_addr < dp[i]) begin
            nd = m[i][rd_addr];
            if (md[i] == 0 && wr_en && wr_addr == rd_addr)
              for (int k = 0; k < 2; k++) if (wr_be[k]) nd[k*8 +: 8] = wr_data[k*8 +: 8];
          end
        end
        ne = (rd_en && rd_addr >= dp[i]) || (wr_en && wr_addr >= dp[i] && wr_be != 0);
        if (wr_en && wr_addr < dp[i])
          for (int k = 0; k < 2; k++) if (wr_be[k]) m[i][wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
        if (clear) begin
          for (int j = 0; j < 8; j++) m[i][j] = 0;
          cnt[i] = dp[i];
        end
      end
      s2d[i] = s1d[i]; s2v[i] = s1v[i]; s1d[i] = nd; s1v[i] = nv; e[i] = ne;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks += 4;
      if (ob[i] !== 1'b1) begin failures++; $display("FAIL reset_busy%0d act=%b exp=1", i, ob[i]); end
      if (ov[i] !== 1'b0) begin failures++; $display("FAIL reset_valid%0d act=%b exp=0", i, ov[i]); end
      if (od[i] !== 16'h0) begin failures++; $display("FAIL reset_data%0d act=%h exp=0000", i, od[i]); end
      if (oe[i] !== 1'b0) begin failures++; $display("FAIL reset_err%0d act=%b exp=0", i, oe[i]); end
    end
    rst_n = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ob[i] !== (c < dp[i])) begin failures++; $display("FAIL init_busy%0d c=%0d act=%b exp=%b", i, c, ob[i], c < dp[i]); end
      end
    end
    for (int a = 0; a < 8; a++) begin
      rd_en = 1; rd_addr = 3'(a);
      tick();
      checks += 2;
      if (od[0] !== 16'h0 || ov[0] !== 1'b1) begin failures++; $display("FAIL init_read a=%0d act=%h/%b exp=0000/1", a, od[0], ov[0]); end
      if (od[1] !== ed(1) || ov[1] !== ev(1)) begin failures++; $display("FAIL init_read_b a=%0d act=%h/%b exp=%h/%b", a, od[1], ov[1], ed(1), ev(1)); end
    end
    idle();
    repeat (2) tick();
  endtask
  task automatic test_write_read();
    wr_en = 1; wr_addr = 3; wr_data = 16'hA5C3; wr_be = 2'b11;
    tick();
    idle();
    rd_en = 1; rd_addr = 3;
    tick();
    idle();
    checks++;
    if (od[0] !== 16'hA5C3 || ov[0] !== 1'b1) begin failures++; $display("FAIL wr_rd act=%h/%b exp=a5c3/1", od[0], ov[0]); end
    tick();
    checks += 2;
    if (od[1] !== 16'hA5C3 || ov[1] !== 1'b1) begin failures++; $display("FAIL wr_rd_lat2 act=%h/%b exp=a5c3/1", od[1], ov[1]); end
    if (od[0] !== 16'hA5C3 || ov[0] !== 1'b0) begin failures++; $display("FAIL rd_hold act=%h/%b exp=a5c3/0", od[0], ov[0]); end
  endtask
  task automatic test_rdw();
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234; wr_be = 2'b01; rd_en = 1; rd_addr = 3;
    tick();
    idle();
    checks++;
    if (od[0] !== 16'hA534) begin failures++; $display("FAIL rdw_write_first act=%h exp=a534", od[0]); end
    tick();
    checks++;
    if (od[1] !== 16'hA5C3 || ov[1] !== 1'b1) begin failures++; $display("FAIL rdw_read_first act=%h/%b exp=a5c3/1", od[1], ov[1]); end
    rd_en = 1; rd_addr = 3;
    tick();
    idle();
    checks++;
    if (od[0] !== 16'hA534) begin failures++; $display("FAIL rdw_after_a act=%h exp=a534", od[0]); end
    tick();
    checks++;
    if (od[1] !== 16'hA534) begin failures++; $display("FAIL rdw_after_b act=%h exp=a534", od[1]); end
  endtask
  task automatic test_out_of_range();
    wr_en = 1; wr_addr = 7; wr_data = 16'hFFFF; wr_be = 2'b11; rd_en = 1; rd_addr = 7;
    tick();
    idle();
    checks += 3;
    if (oe[1] !== 1'b1) begin failures++; $display("FAIL oor_err act=%b exp=1", oe[1]); end
    if (oe[0] !== 1'b0) begin failures++; $display("FAIL oor_err_a act=%b exp=0", oe[0]); end
    if (od[0] !== ed(0)) begin failures++; $display("FAIL oor_inrange_a act=%h exp=%h", od[0], ed(0)); end
    tick();
    checks += 2;
    if (oe[1] !== 1'b0) begin failures++; $display("FAIL oor_err_pulse act=%b exp=0", oe[1]); end
    if (od[1] !== 16'h0 || ov[1] !== 1'b1) begin failures++; $display("FAIL oor_read act=%h/%b exp=0000/1", od[1], ov[1]); end
    for (int a = 0; a < 8; a++) begin
      rd_en = a < 6; rd_addr = 3'(a);
      tick();
      checks++;
      if (od[1] !== ed(1) || ov[1] !== ev(1)) begin failures++; $display("FAIL oor_scan a=%0d act=%h/%b exp=%h/%b", a, od[1], ov[1], ed(1), ev(1)); end
    end
    idle();
  endtask
  task automatic test_clear();
    for (int a = 0; a < 8; a++) begin
      wr_en = 1; wr_addr = 3'(a); wr_data = 16'(16'h1111 * (a + 1)); wr_be = 2'b11;
      tick();
    end
    idle();
    clear = 1;
    tick();
    clear = 0;
    for (int c = 1; c <= 8; c++) begin
      rd_en = 1; rd_addr = 3'(c - 1);
      tick();
      checks++;
      if (ov[0] !== 1'b0 || ob[0] !== (c < 8)) begin failures++; $display("FAIL clear_busy c=%0d act=%b/%b exp=0/%b", c, ov[0], ob[0], c < 8); end
    end
    for (int a = 0; a < 8; a++) begin
      rd_en = 1; rd_addr = 3'(a);
      tick();
      checks++;
      if (od[0] !== 16'h0 || ov[0] !== 1'b1) begin failures++; $display("FAIL clear_read a=%0d act=%h/%b exp=0000/1", a, od[0], ov[0]); end
    end
    idle();
    repeat (2) tick();
  endtask
  task automatic test_reset_mid();
    clear = 1;
    tick();
    clear = 0;
    repeat (4) tick();
    rst_n = 0;
    model_reset();
    #3;
    checks += 2;
    if (ob[0] !== 1'b1 || ov[0] !== 1'b0) begin failures++; $display("FAIL mid_reset act=%b/%b exp=1/0", ob[0], ov[0]); end
    if (od[1] !== 16'h0) begin failures++; $display("FAIL mid_reset_data act=%h exp=0000", od[1]); end
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ob[i] !== (c < dp[i])) begin failures++; $display("FAIL mid_busy%0d c=%0d act=%b exp=%b", i, c, ob[i], c < dp[i]); end
      end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      clear = $urandom_range(0, 60) == 0;
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      wr_be = 2'($urandom_range(0, 3));
      if (wr_addr > 5 && wr_be == 0) wr_be = 2'b01;
      rd_en = $urandom_range(0, 3) != 0;
      rd_addr = $urandom_range(0, 3) == 0 ? wr_addr : 3'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (od[i] !== ed(i) || ov[i] !== ev(i) || oe[i] !== e[i] || ob[i] !== (cnt[i] > 0)) begin
          failures++;
          $display("FAIL rand%0d n=%0d act=%h/%b/%b/%b exp=%h/%b/%b/%b", i, n, od[i], ov[i], oe[i], ob[i], ed(i), ev(i), e[i], cnt[i] > 0);
        end
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_rdw();
    test_out_of_range();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
